// File: rtl/dtlb_gen_pkg.sv
// Shared types and width helpers for the parametrised data TLB.
// Pure declarations; no logic, no latency, no flow control.
// Included first so the payload-width default is visible to the top.
`ifndef dtlbData_width
`define dtlbData_width 64
`endif

package dtlb_gen_pkg;

  localparam int DEF_WAYS   = 8;
  localparam int DEF_SETS   = 16;
  localparam int DEF_RPORTS = 6;
  localparam int DEF_VPN_W  = 50;
  localparam int DEF_ASID_W = 21;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_FLUSH
  } state_t;

  // Index width for n items, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dtlb_gen_lru_set.sv
// Per-set replacement unit: picks matching/first-invalid/oldest way and promotes it.
// Combinational, zero latency.
// No flow control; the caller decides whether the new ages are written back.
module dtlb_gen_lru_set
  import dtlb_gen_pkg::*;
#(
  parameter  int WAYS = DEF_WAYS,
  localparam int AW   = idx_w(WAYS)
) (
  input  logic [WAYS-1:0][AW-1:0] age,
  input  logic [WAYS-1:0]         vld,
  input  logic [WAYS-1:0]         match,
  output logic [AW-1:0]           victim,
  output logic [WAYS-1:0][AW-1:0] age_nxt
);

  always_comb begin
    victim = '0;
    // Later loops override earlier ones: match beats invalid beats oldest.
    for (int w = WAYS - 1; w >= 0; w--)
      if (age[w] == AW'(WAYS - 1)) victim = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (!vld[w]) victim = AW'(w);
    for (int w = WAYS - 1; w >= 0; w--)
      if (match[w]) victim = AW'(w);
  end

  always_comb begin
    age_nxt = age;
    for (int w = 0; w < WAYS; w++) begin
      if (AW'(w) == victim)
        age_nxt[w] = '0;
      else if (age[w] < age[victim])
        age_nxt[w] = age[w] + 1'b1;
    end
  end

endmodule

// File: rtl/dtlb_gen.sv
// Set-associative ASID-tagged data TLB with refill/invalidate port and flush engine.
// Lookups combinational (zero latency); writes and flush sweeps take effect next edge.
// wr_rdy low while initialising, flushing, or when a flush is being requested.
module dtlb_gen
  import dtlb_gen_pkg::*;
#(
  parameter  int WAYS   = DEF_WAYS,
  parameter  int SETS   = DEF_SETS,
  parameter  int RPORTS = DEF_RPORTS,
  parameter  int VPN_W  = DEF_VPN_W,
  parameter  int ASID_W = DEF_ASID_W,
  parameter  int DATA_W = `dtlbData_width,
  localparam int AW     = idx_w(WAYS),
  localparam int SW     = idx_w(SETS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [ASID_W-1:0]              cur_asid,
  input  logic [RPORTS-1:0]              rd_en,
  input  logic [RPORTS-1:0][VPN_W-1:0]   rd_vpn,
  output logic [RPORTS-1:0]              rd_hit,
  output logic [RPORTS-1:0][DATA_W-1:0]  rd_data,
  output logic [RPORTS-1:0][AW-1:0]      rd_way,
  input  logic                           wr_en,
  output logic                           wr_rdy,
  input  logic [VPN_W-1:0]               wr_vpn,
  input  logic [ASID_W-1:0]              wr_asid,
  input  logic                           wr_glo,
  input  logic                           wr_invl,
  input  logic [DATA_W-1:0]              wr_data,
  input  logic                           flush_req,
  input  logic                           flush_asid_mode,
  input  logic [ASID_W-1:0]              flush_asid,
  output logic                           busy,
  output logic                           flush_done
);

  localparam logic [SW-1:0] LAST = SW'(SETS - 1);

  typedef struct packed {
    logic              valid;
    logic              glo;
    logic [ASID_W-1:0] asid;
    logic [VPN_W-1:0]  vpn;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t                  ent [SETS][WAYS];
  logic [WAYS-1:0][AW-1:0] age [SETS];

  state_t            state, state_nxt;
  logic [SW-1:0]     cnt;
  logic              fl_mode;
  logic [ASID_W-1:0] fl_asid;

  always_comb begin
    state_nxt  = state;
    busy       = 1'b1;
    wr_rdy     = 1'b0;
    flush_done = 1'b0;
    case (state)
      ST_INIT:  if (cnt == LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        busy   = 1'b0;
        wr_rdy = !flush_req;
        if (flush_req) state_nxt = ST_FLUSH;
      end
      ST_FLUSH: if (cnt == LAST) begin
        flush_done = 1'b1;
        state_nxt  = ST_IDLE;
      end
      default:  state_nxt = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_INIT;
      cnt     <= '0;
      fl_mode <= 1'b0;
      fl_asid <= '0;
    end else begin
      state <= state_nxt;
      if (state == ST_IDLE) begin
        cnt <= '0;
        if (flush_req) begin
          fl_mode <= flush_asid_mode;
          fl_asid <= flush_asid;
        end
      end else begin
        cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
      end
    end
  end

  // Lookup
  logic [RPORTS-1:0][WAYS-1:0] hit_vec;

  always_comb begin
    hit_vec = '0;
    rd_data = '0;
    for (int p = 0; p < RPORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        if (rd_en[p] && !busy && ent[rd_vpn[p][SW-1:0]][w].valid &&
            ent[rd_vpn[p][SW-1:0]][w].vpn == rd_vpn[p] &&
            (ent[rd_vpn[p][SW-1:0]][w].glo || ent[rd_vpn[p][SW-1:0]][w].asid == cur_asid)) begin
          hit_vec[p][w] = 1'b1;
          rd_data[p]    = rd_data[p] | ent[rd_vpn[p][SW-1:0]][w].data;
        end
      end
      rd_hit[p] = |hit_vec[p];
    end
  end

  // Write side
  logic [SW-1:0]           wset;
  logic [WAYS-1:0]         wvld, wmatch;
  logic [AW-1:0]           w_victim;
  logic [WAYS-1:0][AW-1:0] w_age_nxt;
  logic                    wr_acc;

  assign wset   = wr_vpn[SW-1:0];
  assign wr_acc = wr_en && wr_rdy;

  always_comb begin
    wvld   = '0;
    wmatch = '0;
    for (int w = 0; w < WAYS; w++) begin
      wvld[w]   = ent[wset][w].valid;
      wmatch[w] = ent[wset][w].valid && ent[wset][w].vpn == wr_vpn &&
                  (ent[wset][w].glo || ent[wset][w].asid == wr_asid);
    end
  end

  dtlb_gen_lru_set #(.WAYS(WAYS)) u_lru_wr (
    .age     (age[wset]),
    .vld     (wvld),
    .match   (wmatch),
    .victim  (w_victim),
    .age_nxt (w_age_nxt)
  );

  // Port 0 hit promotion; its encoded way doubles as rd_way[0].
  logic [SW-1:0]           p0_set;
  logic [AW-1:0]           p0_way;
  logic [WAYS-1:0][AW-1:0] p0_age_nxt;
  logic                    p0_promote;

  assign p0_set     = rd_vpn[0][SW-1:0];
  assign p0_promote = rd_hit[0] && !(wr_acc && wset == p0_set);

  dtlb_gen_lru_set #(.WAYS(WAYS)) u_lru_rd (
    .age     (age[p0_set]),
    .vld     ({WAYS{1'b1}}),
    .match   (hit_vec[0]),
    .victim  (p0_way),
    .age_nxt (p0_age_nxt)
  );

  always_comb begin
    rd_way = '0;
    for (int p = 1; p < RPORTS; p++)
      for (int w = 0; w < WAYS; w++)
        if (hit_vec[p][w]) rd_way[p] = rd_way[p] | AW'(w);
    if (rd_hit[0]) rd_way[0] = p0_way;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      case (state)
        ST_INIT: begin
          for (int w = 0; w < WAYS; w++) begin
            ent[cnt][w].valid <= 1'b0;
            age[cnt][w]       <= AW'(w);
          end
        end
        ST_FLUSH: begin
          for (int w = 0; w < WAYS; w++)
            if (!fl_mode || (ent[cnt][w].asid == fl_asid && !ent[cnt][w].glo))
              ent[cnt][w].valid <= 1'b0;
        end
        default: begin
          if (p0_promote) age[p0_set] <= p0_age_nxt;
          if (wr_acc) begin
            if (wr_invl) begin
              if (|wmatch) ent[wset][w_victim].valid <= 1'b0;
            end else begin
              ent[wset][w_victim] <= '{valid: 1'b1, glo: wr_glo, asid: wr_asid,
                                       vpn: wr_vpn, data: wr_data};
              age[wset]           <= w_age_nxt;
            end
          end
        end
      endcase
    end
  end

endmodule
